pwm_multi: RTL and testbench

PWM_MULTI -- requirements
Module: pwm_multi

---
 rtl/pwm_multi.sv | 213 +++++++++++++++++++++
 tb/tb_pwm_multi.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator with double-buffered period/duty.
//
// A shared counter is compared against per-channel duty values. Period and
// duty are captured into shadow registers on a load strobe and moved into
// the active registers only at a cycle boundary. Outputs never tear
// mid-cycle as a result.
//
// Build option: define PWM_CENTER_ALIGN_EN for triangle (center-aligned)
// counting. Without it the counter is an edge-aligned sawtooth. The port
// list is the same in both builds.
module pwm_multi #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    input  logic                      load,
    output logic                      pending,
    output logic                      sync,
    output logic [CHANNELS-1:0]       sig_out
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]          cnt_q,      cnt_d;
    logic [WIDTH-1:0]          period_a_q, period_a_d;
    logic [CHANNELS*WIDTH-1:0] duty_a_q,   duty_a_d;
    logic [WIDTH-1:0]          period_s_q, period_s_d;
    logic [CHANNELS*WIDTH-1:0] duty_s_q,   duty_s_d;
    logic                      pending_q,  pending_d;
    logic                      sync_q,     sync_d;
    logic [CHANNELS-1:0]       sig_q,      sig_d;
`ifdef PWM_CENTER_ALIGN_EN
    // Slope direction of the triangle counter: 0 = counting up, 1 = down.
    logic                      dir_q,      dir_d;
`endif

    // High on the edge that ends the current PWM cycle.
    logic                      boundary_s;

    // Extract the active duty value of one channel.
    function automatic logic [WIDTH-1:0] duty_of(
        input logic [CHANNELS*WIDTH-1:0] vec,
        input int                        ch
    );
        duty_of = vec[ch*WIDTH +: WIDTH];
    endfunction

`ifdef PWM_CENTER_ALIGN_EN
    // Triangle counter: 0,1..P,P-1..1 repeating; the boundary is the edge
    // leaving 1 on the down slope (or every edge for P = 0, and the edge
    // leaving the top state for P = 1).
    always_comb begin
        cnt_d      = '0;
        dir_d      = 1'b0;
        boundary_s = 1'b0;
        if (!enable) begin
            cnt_d      = '0;
            dir_d      = 1'b0;
            boundary_s = 1'b0;
        end else if (period_a_q == '0) begin
            cnt_d      = '0;
            dir_d      = 1'b0;
            boundary_s = 1'b1;
        end else if (!dir_q) begin
            if (cnt_q >= period_a_q) begin
                if (period_a_q == WIDTH'(1)) begin
                    cnt_d      = '0;
                    dir_d      = 1'b0;
                    boundary_s = 1'b1;
                end else begin
                    cnt_d      = cnt_q - WIDTH'(1);
                    dir_d      = 1'b1;
                    boundary_s = 1'b0;
                end
            end else begin
                cnt_d      = cnt_q + WIDTH'(1);
                dir_d      = 1'b0;
                boundary_s = 1'b0;
            end
        end else begin
            if (cnt_q <= WIDTH'(1)) begin
                cnt_d      = '0;
                dir_d      = 1'b0;
                boundary_s = 1'b1;
            end else begin
                cnt_d      = cnt_q - WIDTH'(1);
                dir_d      = 1'b1;
                boundary_s = 1'b0;
            end
        end
    end
`else
    // Sawtooth counter: wraps to 0 after reaching the active period. The
    // >= guard keeps the count bounded even if it ever exceeds the period.
    always_comb begin
        cnt_d      = '0;
        boundary_s = 1'b0;
        if (!enable) begin
            cnt_d      = '0;
            boundary_s = 1'b0;
        end else if (cnt_q >= period_a_q) begin
            cnt_d      = '0;
            boundary_s = 1'b1;
        end else begin
            cnt_d      = cnt_q + WIDTH'(1);
            boundary_s = 1'b0;
        end
    end
`endif

    // Shadow capture and shadow-to-active transfer.
    always_comb begin
        period_s_d = period_s_q;
        duty_s_d   = duty_s_q;
        period_a_d = period_a_q;
        duty_a_d   = duty_a_q;
        pending_d  = pending_q;

        if (load) begin
            period_s_d = period;
            duty_s_d   = duty;
        end else begin
            period_s_d = period_s_q;
            duty_s_d   = duty_s_q;
        end

        if (!enable) begin
            // Idle block: nothing is being generated, so a load can take
            // effect at once without a boundary.
            if (load) begin
                period_a_d = period;
                duty_a_d   = duty;
                pending_d  = 1'b0;
            end else begin
                pending_d  = pending_q;
            end
        end else if (boundary_s) begin
            // A load on the boundary edge bypasses the shadow wait.
            if (load) begin
                period_a_d = period;
                duty_a_d   = duty;
                pending_d  = 1'b0;
            end else if (pending_q) begin
                period_a_d = period_s_q;
                duty_a_d   = duty_s_q;
                pending_d  = 1'b0;
            end else begin
                pending_d  = 1'b0;
            end
        end else begin
            if (load) begin
                pending_d = 1'b1;
            end else begin
                pending_d = pending_q;
            end
        end
    end

    // Compare stage: outputs reflect the count of the previous cycle, so
    // sync and every channel stay aligned to each other.
    always_comb begin
        sig_d  = '0;
        sync_d = 1'b0;
        if (enable) begin
            for (int i = 0; i < CHANNELS; i++) begin
                sig_d[i] = (cnt_q < duty_of(duty_a_q, i));
            end
            sync_d = (cnt_q == '0);
        end else begin
            sig_d  = '0;
            sync_d = 1'b0;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            period_a_q <= '0;
            duty_a_q   <= '0;
            period_s_q <= '0;
            duty_s_q   <= '0;
            pending_q  <= 1'b0;
            sync_q     <= 1'b0;
            sig_q      <= '0;
`ifdef PWM_CENTER_ALIGN_EN
            dir_q      <= 1'b0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            period_a_q <= period_a_d;
            duty_a_q   <= duty_a_d;
            period_s_q <= period_s_d;
            duty_s_q   <= duty_s_d;
            pending_q  <= pending_d;
            sync_q     <= sync_d;
            sig_q      <= sig_d;
`ifdef PWM_CENTER_ALIGN_EN
            dir_q      <= dir_d;
`endif
        end
    end

    assign pending = pending_q;
    assign sync    = sync_q;
    assign sig_out = sig_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Testbench for pwm_multi (WIDTH=8, CHANNELS=4). A phase-based reference
// model predicts sig_out/sync/pending every clock; directed scenarios add
// pulse-width counts derived directly from the period/duty rules.
module tb_pwm_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [7:0]  period;
    logic [31:0] duty;
    logic        load;
    logic        pending;
    logic        sync;
    logic [3:0]  sig_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: position within the current cycle plus the
    // active/shadow settings.
    int       m_ph;
    int       m_per;
    int       m_duty [4];
    int       m_sh_per;
    int       m_sh_duty [4];
    bit       m_pend;
    logic [3:0] m_sig;
    logic     m_sync;

    int meas_h [4];
    int meas_s;

    pwm_multi #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .period  (period),
        .duty    (duty),
        .load    (load),
        .pending (pending),
        .sync    (sync),
        .sig_out (sig_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Cycle length for a given period.
    function automatic int m_len(int p);
`ifdef PWM_CENTER_ALIGN_EN
        return (p == 0) ? 1 : 2 * p;
`else
        return p + 1;
`endif
    endfunction

    // Count value at a given phase of the cycle.
    function automatic int m_cnt(int ph, int p);
`ifdef PWM_CENTER_ALIGN_EN
        return (ph <= p) ? ph : 2 * p - ph;
`else
        return ph;
`endif
    endfunction

    task automatic model_reset();
        m_ph = 0; m_per = 0; m_sh_per = 0; m_pend = 1'b0;
        m_sig = 4'b0000; m_sync = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_duty[i] = 0; m_sh_duty[i] = 0;
        end
    endtask

    task automatic model_step();
        int c;
        bit bnd;
        c = m_cnt(m_ph, m_per);
        if (!enable) begin
            m_sig = 4'b0000; m_sync = 1'b0; m_ph = 0;
            if (load) begin
                m_per = int'(period); m_sh_per = int'(period); m_pend = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    m_duty[i] = int'(duty[i*8 +: 8]); m_sh_duty[i] = m_duty[i];
                end
            end
        end else begin
            for (int i = 0; i < 4; i++) m_sig[i] = (c < m_duty[i]);
            m_sync = (c == 0);
            bnd = (m_ph >= m_len(m_per) - 1);
            m_ph = bnd ? 0 : m_ph + 1;
            if (load) begin
                m_sh_per = int'(period);
                for (int i = 0; i < 4; i++) m_sh_duty[i] = int'(duty[i*8 +: 8]);
                if (bnd) begin
                    m_per = m_sh_per;
                    for (int i = 0; i < 4; i++) m_duty[i] = m_sh_duty[i];
                    m_pend = 1'b0;
                end else begin
                    m_pend = 1'b1;
                end
            end else if (bnd && m_pend) begin
                m_per = m_sh_per;
                for (int i = 0; i < 4; i++) m_duty[i] = m_sh_duty[i];
                m_pend = 1'b0;
            end
        end
    endtask

    // One clock: model follows the edge, then return at the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // Accumulate output highs over the 10 output cycles starting now.
    task automatic measure10();
        for (int i = 0; i < 4; i++) meas_h[i] = 0;
        meas_s = 0;
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 4; i++) meas_h[i] += int'(sig_out[i]);
            meas_s += int'(sync);
            cycle();
        end
    endtask

    // Advance (bounded) until an observed sync pulse; returns 1 if found.
    task automatic wait_sync(output bit found);
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (sync === 1'b1) begin
                found = 1'b1;
                break;
            end
            cycle();
        end
    endtask

    // Advance (bounded) until the count about to be clocked equals c.
    task automatic wait_cnt(input int c, output bit found);
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (m_cnt(m_ph, m_per) == c) begin
                found = 1'b1;
                break;
            end
            cycle();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; load = 1'b0; period = 8'd0; duty = 32'd0;
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (sig_out !== 4'b0000) begin
            n_fail++; $display("FAIL reset_sig_out actual=%b required=%b", sig_out, 4'b0000);
        end
        n_checks++;
        if (sync !== 1'b0) begin
            n_fail++; $display("FAIL reset_sync actual=%b required=0", sync);
        end
        n_checks++;
        if (pending !== 1'b0) begin
            n_fail++; $display("FAIL reset_pending actual=%b required=0", pending);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit found;
        period = 8'd9; duty = {8'd255, 8'd10, 8'd3, 8'd0}; load = 1'b1; enable = 1'b0;
        cycle();
        load = 1'b0; enable = 1'b1;
        for (int k = 0; k < 25; k++) begin
            cycle();
            n_checks++;
            if (sig_out !== m_sig || sync !== m_sync || pending !== m_pend) begin
                n_fail++;
                $display("FAIL basic_model k=%0d actual sig=%b sync=%b pend=%b required sig=%b sync=%b pend=%b",
                         k, sig_out, sync, pending, m_sig, m_sync, m_pend);
            end
        end
        wait_sync(found);
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL basic_sync_seen actual=none required=pulse");
        end
        measure10();
        n_checks++;
        if (meas_h[0] != 0 || meas_h[1] != 3 || meas_h[2] != 10 || meas_h[3] != 10 || meas_s != 1) begin
            n_fail++;
            $display("FAIL basic_widths actual=%0d/%0d/%0d/%0d sync=%0d required=0/3/10/10 sync=1",
                     meas_h[0], meas_h[1], meas_h[2], meas_h[3], meas_s);
        end
    endtask

    task automatic test_midcycle_load();
        bit found;
        int pend_hi;
        wait_cnt(4, found);
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL mid_reach_cnt4 actual=none required=cnt4");
        end
        duty[15:8] = 8'd7; load = 1'b1;
        cycle();
        load = 1'b0;
        pend_hi = 0;
        for (int k = 0; k < 12; k++) begin
            pend_hi += int'(pending);
            n_checks++;
            if (sig_out !== m_sig || sync !== m_sync || pending !== m_pend) begin
                n_fail++;
                $display("FAIL mid_model k=%0d actual sig=%b sync=%b pend=%b required sig=%b sync=%b pend=%b",
                         k, sig_out, sync, pending, m_sig, m_sync, m_pend);
            end
            cycle();
        end
        n_checks++;
        if (pend_hi != 5) begin
            n_fail++; $display("FAIL mid_pending_cycles actual=%0d required=5", pend_hi);
        end
        wait_sync(found);
        measure10();
        n_checks++;
        if (!found || meas_h[1] != 7) begin
            n_fail++; $display("FAIL mid_new_width actual=%0d required=7", meas_h[1]);
        end
    endtask

    task automatic test_boundary_load();
        bit found;
        int pend_hi;
        wait_cnt(9, found);
        duty[15:8] = 8'd5; load = 1'b1;
        cycle();
        load = 1'b0;
        pend_hi = int'(pending);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (sig_out !== m_sig || sync !== m_sync || pending !== m_pend) begin
                n_fail++;
                $display("FAIL bnd_model k=%0d actual sig=%b sync=%b pend=%b required sig=%b sync=%b pend=%b",
                         k, sig_out, sync, pending, m_sig, m_sync, m_pend);
            end
            cycle();
            pend_hi += int'(pending);
        end
        wait_sync(found);
        measure10();
        n_checks++;
        if (!found || meas_h[1] != 5) begin
            n_fail++; $display("FAIL bnd_new_width actual=%0d required=5", meas_h[1]);
        end
        n_checks++;
        if (pend_hi != 0) begin
            n_fail++; $display("FAIL bnd_pending_seen actual=%0d required=0", pend_hi);
        end
    endtask

    task automatic test_enable();
        bit found;
        wait_cnt(5, found);
        enable = 1'b0;
        cycle();
        n_checks++;
        if (!found || sig_out !== 4'b0000 || sync !== 1'b0) begin
            n_fail++; $display("FAIL dis_outputs actual sig=%b sync=%b required sig=0000 sync=0", sig_out, sync);
        end
        repeat (3) cycle();
        enable = 1'b1;
        cycle();
        n_checks++;
        if (sync !== 1'b1 || sig_out !== m_sig) begin
            n_fail++; $display("FAIL reen_first actual sync=%b sig=%b required sync=1 sig=%b", sync, sig_out, m_sig);
        end
        enable = 1'b0;
        cycle();
        period = 8'd0; duty = {8'd0, 8'd0, 8'd0, 8'd1}; load = 1'b1;
        cycle();
        load = 1'b0; enable = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            n_checks++;
            if (sig_out !== 4'b0001 || sync !== 1'b1 || pending !== 1'b0) begin
                n_fail++;
                $display("FAIL per0_const k=%0d actual sig=%b sync=%b pend=%b required sig=0001 sync=1 pend=0",
                         k, sig_out, sync, pending);
            end
        end
    endtask

    task automatic test_async_reset();
        bit found;
        period = 8'd9; duty = {8'd255, 8'd4, 8'd2, 8'd6}; load = 1'b1;
        cycle();
        load = 1'b0;
        wait_cnt(3, found);
        duty = {8'd255, 8'd1, 8'd1, 8'd1}; load = 1'b1;
        cycle();
        load = 1'b0;
        n_checks++;
        if (pending !== 1'b1 || sig_out[3] !== 1'b1) begin
            n_fail++; $display("FAIL arst_setup actual pend=%b sig3=%b required pend=1 sig3=1", pending, sig_out[3]);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (sig_out !== 4'b0000 || sync !== 1'b0 || pending !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_immediate actual sig=%b sync=%b pend=%b required all 0", sig_out, sync, pending);
        end
        model_reset();
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            n_checks++;
            if (sig_out !== 4'b0000 || sync !== 1'b0 || pending !== 1'b0) begin
                n_fail++;
                $display("FAIL arst_idle k=%0d actual sig=%b sync=%b pend=%b required all 0", k, sig_out, sync, pending);
            end
        end
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            n_checks++;
            if (sig_out !== 4'b0000 || pending !== 1'b0) begin
                n_fail++;
                $display("FAIL arst_discard k=%0d actual sig=%b pend=%b required sig=0000 pend=0", k, sig_out, pending);
            end
        end
    endtask

    task automatic test_random();
        int r;
        for (int k = 0; k < 400; k++) begin
            enable = ($urandom_range(0, 15) != 0);
            load   = ($urandom_range(0, 7) == 0);
            period = 8'($urandom_range(0, 12));
            for (int i = 0; i < 4; i++) begin
                r = $urandom_range(0, 9);
                duty[i*8 +: 8] = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : 8'($urandom_range(0, 14));
            end
            cycle();
            n_checks++;
            if (sig_out !== m_sig || sync !== m_sync || pending !== m_pend) begin
                n_fail++;
                $display("FAIL rand_model k=%0d actual sig=%b sync=%b pend=%b required sig=%b sync=%b pend=%b",
                         k, sig_out, sync, pending, m_sig, m_sync, m_pend);
            end
        end
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_midcycle_load();
        test_boundary_load();
        test_enable();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
